// File: rtl/lim_port_arbiter.sv
// lim_port_arbiter
// Arbitrates an instruction read port and a data (read/write/LiM) port onto a
// single logic-in-memory port. One access is outstanding at a time; the
// requests alternate round-robin when both ports ask in the same cycle.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   instr_*              instruction read port (req/addr in, gnt/rvalid/rdata out)
//   data_*               data port (req/we/be/addr/wdata/funct in,
//                        gnt/rvalid/rdata/err out)
//   mem_*                memory side (en/we/be/addr/wdata/funct out,
//                        valid/rdata in)
//   busy_o               high whenever an access is in flight or responding
module lim_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 22,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  // instruction port
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  // data port
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [7:0]            data_funct_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  // memory side
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [7:0]            mem_funct_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  // Plain (non-LiM) access function code.
  localparam logic [7:0] FUNCT_NULL   = 8'h00;
  localparam logic [9:0] TIMEOUT_LOAD = 10'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                r_state;
  state_e                w_state_next;

  logic                  r_last_data;   // last grant went to the data port
  logic                  r_owner_data;  // current access belongs to the data port
  logic                  r_we;
  logic [3:0]            r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_funct;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [9:0]            r_cnt;

  logic                  w_grant_instr;
  logic                  w_grant_data;
  logic                  w_grant_any;
  logic                  w_skip;
  logic                  w_timeout;
  logic                  w_resp;

  // Arbitration. Gated by rstn_i so no grant leaks out while reset is held.
  always_comb begin
    w_grant_instr = 1'b0;
    w_grant_data  = 1'b0;
    if ((r_state == StIdle) && rstn_i) begin
      if (instr_req_i && data_req_i) begin
        // Tie: the port that did not win last time goes now.
        if (r_last_data) begin
          w_grant_instr = 1'b1;
        end else begin
          w_grant_data = 1'b1;
        end
      end else if (instr_req_i) begin
        w_grant_instr = 1'b1;
      end else if (data_req_i) begin
        w_grant_data = 1'b1;
      end
    end
  end

  assign w_grant_any = w_grant_instr | w_grant_data;
  // A write with no byte lanes enabled has nothing to do in memory.
  assign w_skip      = w_grant_data & data_we_i & (data_be_i == 4'b0000);

  // Next state. The counter is loaded with the timeout on grant and the last
  // allowed BUSY cycle is the one where it would step from 1 to 0.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant_any) begin
          w_state_next = w_skip ? StResp : StBusy;
        end
      end
      StBusy: begin
        if (mem_valid_i) begin
          w_state_next = StResp;
        end else if (r_cnt <= 10'd1) begin
          w_timeout    = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_last_data  <= 1'b0;
      r_owner_data <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= 4'b0000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct      <= 8'h00;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= 10'd0;
    end else if (w_grant_any) begin
      r_last_data  <= w_grant_data;
      r_owner_data <= w_grant_data;
      r_we         <= w_grant_data ? data_we_i : 1'b0;
      r_be         <= w_grant_data ? data_be_i : 4'b1111;
      r_addr       <= w_grant_data ? data_addr_i : instr_addr_i;
      r_wdata      <= w_grant_data ? data_wdata_i : '0;
      r_funct      <= w_grant_data ? data_funct_i : FUNCT_NULL;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= TIMEOUT_LOAD;
    end else if (r_state == StBusy) begin
      if (r_cnt != 10'd0) begin
        r_cnt <= r_cnt - 10'd1;
      end
      if (mem_valid_i) begin
        r_rdata <= r_we ? '0 : mem_rdata_i;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign w_resp = (r_state == StResp);

  always_comb begin
    instr_gnt_o    = w_grant_instr;
    data_gnt_o     = w_grant_data;
    instr_rvalid_o = w_resp & ~r_owner_data;
    data_rvalid_o  = w_resp & r_owner_data;
    instr_rdata_o  = instr_rvalid_o ? r_rdata : '0;
    data_rdata_o   = data_rvalid_o ? r_rdata : '0;
    data_err_o     = data_rvalid_o & r_err;
    mem_en_o       = (r_state == StBusy);
    mem_we_o       = mem_en_o & r_we;
    mem_be_o       = mem_en_o ? r_be : 4'b0000;
    mem_addr_o     = mem_en_o ? r_addr : '0;
    mem_wdata_o    = mem_en_o ? r_wdata : '0;
    mem_funct_o    = mem_en_o ? r_funct : 8'h00;
    busy_o         = (r_state != StIdle);
  end

endmodule

// File: tb/tb_lim_port_arbiter.sv
// Self-checking bench for lim_port_arbiter: directed corner cases followed by
// randomized transactions, each checked against a transaction-level model.
module tb_lim_port_arbiter;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam logic [7:0] FUNCT_NULL = 8'h00;
  localparam logic [7:0] FUNCT_AND  = 8'h01;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic [7:0]    data_funct_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          data_err_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [7:0]    mem_funct_o;
  logic          mem_valid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;
  bit m_last_data;  // model: the data port won the most recent grant

  lim_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_funct_i  (data_funct_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_funct_o   (mem_funct_o),
    .mem_valid_i   (mem_valid_i),
    .mem_rdata_i   (mem_rdata_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_instr();
    instr_req_i  = 1'b1;
    instr_addr_i = AW'($urandom);
  endtask

  task automatic set_data(input logic we, input logic [3:0] be, input logic [7:0] f);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = AW'($urandom);
    data_wdata_i = $urandom;
    data_funct_i = f;
  endtask

  // Serve one access starting from IDLE with requests already driven.
  // lat: cycle of BUSY on which memory answers (0 = never answers).
  task automatic serve(input int lat, input logic [DW-1:0] mdata);
    bit            win_d;
    bit            skip;
    bit            ok;
    int            n;
    logic          e_we;
    logic [3:0]    e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [7:0]    e_funct;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    #1;
    win_d = data_req_i && (!instr_req_i || !m_last_data);
    chk("idle_busy", busy_o, 0);
    chk("idle_mem_en", mem_en_o, 0);
    chk("instr_gnt", instr_gnt_o, !win_d);
    chk("data_gnt", data_gnt_o, win_d);
    if (win_d) begin
      e_we = data_we_i; e_be = data_be_i; e_addr = data_addr_i;
      e_wdata = data_wdata_i; e_funct = data_funct_i;
    end else begin
      e_we = 1'b0; e_be = 4'b1111; e_addr = instr_addr_i;
      e_wdata = '0; e_funct = FUNCT_NULL;
    end
    m_last_data = win_d;
    skip    = win_d && data_we_i && (data_be_i == 4'b0000);
    ok      = (lat >= 1) && (lat <= T);
    e_err   = !skip && !ok;
    e_rdata = (!skip && ok && !e_we) ? mdata : '0;
    tick();
    // The winner lets go and scrambles its fields; the latched copy must hold.
    if (win_d) begin
      data_req_i = 1'b0; data_we_i = 1'($urandom); data_be_i = 4'($urandom);
      data_addr_i = AW'($urandom); data_wdata_i = $urandom; data_funct_i = 8'($urandom);
    end else begin
      instr_req_i = 1'b0; instr_addr_i = AW'($urandom);
    end
    if (!skip) begin
      n = ok ? lat : T;
      for (int i = 1; i <= n; i++) begin
        mem_valid_i = (i == lat);
        mem_rdata_i = (i == lat) ? mdata : $urandom;
        #1;
        chk("busy_mem_en", mem_en_o, 1);
        chk("busy_busy", busy_o, 1);
        chk("mem_we", mem_we_o, e_we);
        chk("mem_be", mem_be_o, e_be);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_funct", mem_funct_o, e_funct);
        if (win_d) chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("busy_gnt", {instr_gnt_o, data_gnt_o}, 0);
        chk("busy_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        tick();
      end
    end
    // Memory chatter outside BUSY must be ignored.
    mem_valid_i = 1'($urandom);
    mem_rdata_i = $urandom;
    #1;
    chk("resp_mem_en", mem_en_o, 0);
    chk("resp_busy", busy_o, 1);
    chk("resp_gnt", {instr_gnt_o, data_gnt_o}, 0);
    chk("instr_rvalid", instr_rvalid_o, !win_d);
    chk("data_rvalid", data_rvalid_o, win_d);
    chk("instr_rdata", instr_rdata_o, win_d ? '0 : e_rdata);
    chk("data_rdata", data_rdata_o, win_d ? e_rdata : '0);
    chk("data_err", data_err_o, win_d && e_err);
    tick();
    mem_valid_i = 1'b0;
    #1;
    chk("back_idle", busy_o, 0);
    chk("idle_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
  endtask

  initial begin
    int sel;
    logic we;
    logic [3:0] be;
    rstn_i = 1'b0;
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'b0000; data_addr_i = '0;
    data_wdata_i = '0; data_funct_i = 8'h00;
    mem_valid_i = 1'b0; mem_rdata_i = '0;
    m_last_data = 1'b0;
    #2;
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o, data_err_o}, 0);
    tick();
    tick();
    rstn_i = 1'b1;
    tick();

    // Idle with no request: stray mem_valid_i has no effect.
    mem_valid_i = 1'b1;
    #1;
    chk("norq_gnt", {instr_gnt_o, data_gnt_o}, 0);
    tick();
    mem_valid_i = 1'b0;
    chk("norq_busy", busy_o, 0);

    // Instruction read at 0x10, memory answers on the 5th BUSY cycle.
    instr_req_i = 1'b1; instr_addr_i = AW'(32'h10);
    serve(5, 32'hDEADBEEF);

    // Ties from reset: data first, then alternation.
    set_instr(); set_data(1'b0, 4'b1111, FUNCT_NULL);
    serve(2, $urandom);
    set_data(1'b0, 4'b1111, FUNCT_NULL);
    serve(3, $urandom);
    set_instr();
    serve(1, $urandom);
    serve(4, $urandom);

    // LiM write with partial byte enables.
    set_data(1'b1, 4'b0011, FUNCT_AND);
    serve(3, $urandom);
    // Empty write skips memory.
    set_data(1'b1, 4'b0000, FUNCT_AND);
    serve(4, $urandom);
    // Timeout, success on the last allowed cycle, and one past it.
    set_data(1'b0, 4'b1111, FUNCT_NULL);
    serve(0, $urandom);
    set_data(1'b0, 4'b1111, FUNCT_NULL);
    serve(T, 32'h12345678);
    set_data(1'b0, 4'b1111, FUNCT_NULL);
    serve(T + 1, $urandom);

    // Reset in the middle of BUSY, request still asserted.
    set_data(1'b0, 4'b1111, FUNCT_NULL);
    tick();
    tick();
    #3;
    rstn_i = 1'b0;
    #1;
    chk("arst_mem_en", mem_en_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_gnt", {instr_gnt_o, data_gnt_o}, 0);
    chk("arst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
    tick();
    chk("arst_hold", {busy_o, mem_en_o, data_rvalid_o}, 0);
    data_req_i = 1'b0;
    m_last_data = 1'b0;
    rstn_i = 1'b1;
    set_instr(); set_data(1'b1, 4'b1100, FUNCT_AND);
    serve(2, $urandom);
    serve(1, $urandom);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 2);
      we  = 1'($urandom);
      be  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if (sel != 1) set_instr();
      if (sel != 0) set_data(we, be, 8'($urandom));
      serve($urandom_range(0, T + 2), $urandom);
      if (sel == 2) serve($urandom_range(0, T + 2), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
